// File: rtl/pwm_serializer.sv
// PWM audio serializer: holds each clip sample for REPEAT PWM periods and
// pulses one_done to fetch the next sample from the play controller.
module pwm_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int PWM_W    = 8,
  parameter int REPEAT   = 8
) (
  input  logic                clock_i,
  input  logic                Reset,
  input  logic                S_enable,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                pwm_o,
  output logic                audio_sd_o,
  output logic                one_done,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;
  localparam logic [RW-1:0]    REP_MAX = RW'(REPEAT - 1);

  state_t           state;
  logic             prime_cnt;
  logic             load_pend;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty;
  logic [RW-1:0]    rep_cnt;
  logic [PWM_W-1:0] sample_top;

  assign sample_top = sample_i[SAMPLE_W-1 -: PWM_W];

  // Only the top PWM_W bits of the sample drive the duty cycle.
  generate
    if (SAMPLE_W > PWM_W) begin : g_low
      logic unused_low;
      assign unused_low = ^sample_i[SAMPLE_W-PWM_W-1:0];
    end
  endgenerate

  always_ff @(posedge clock_i or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      prime_cnt  <= 1'b0;
      load_pend  <= 1'b0;
      pwm_cnt    <= '0;
      rep_cnt    <= '0;
      duty       <= '0;
      pwm_o      <= 1'b0;
      audio_sd_o <= 1'b0;
      one_done   <= 1'b0;
      busy_o     <= 1'b0;
    end else if (!S_enable) begin
      // Dropping enable abandons the current sample without requesting another.
      state      <= IDLE;
      prime_cnt  <= 1'b0;
      load_pend  <= 1'b0;
      pwm_cnt    <= '0;
      rep_cnt    <= '0;
      duty       <= '0;
      pwm_o      <= 1'b0;
      audio_sd_o <= 1'b0;
      one_done   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      // one_done trails each duty load by one clock, straight from a flop.
      one_done  <= load_pend;
      load_pend <= 1'b0;
      case (state)
        IDLE: begin
          state      <= PRIME;
          prime_cnt  <= 1'b0;
          busy_o     <= 1'b1;
          audio_sd_o <= 1'b1;
          pwm_o      <= 1'b0;
        end
        PRIME: begin
          // Two clocks here let the clip memory present the first sample.
          if (!prime_cnt) begin
            prime_cnt <= 1'b1;
          end else begin
            duty      <= sample_top;
            load_pend <= 1'b1;
            pwm_cnt   <= '0;
            rep_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          pwm_o   <= (pwm_cnt < duty);
          pwm_cnt <= pwm_cnt + 1'b1;
          if (pwm_cnt == PWM_MAX) begin
            if (rep_cnt == REP_MAX) begin
              rep_cnt   <= '0;
              duty      <= sample_top;
              load_pend <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_serializer.md
PWM_SERIALIZER -- requirements
Module: pwm_serializer

Interface
REQ-001 Parameter SAMPLE_W, default 16, SHALL set the width of the stored audio sample word.
REQ-002 Parameter PWM_W, default 8, SHALL set the PWM resolution; one PWM period SHALL be 2^PWM_W clocks.
REQ-003 Parameter REPEAT, default 8, SHALL set the number of PWM periods each sample is held (range 1..255).
REQ-004 clock_i  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 S_enable  in  1  playback enable, driven by the record/play controller.
REQ-007 sample_i  in  SAMPLE_W  unsigned offset-binary sample read from clip memory at the controller's current address.
REQ-008 pwm_o  out  1  registered PWM audio output.
REQ-009 audio_sd_o  out  1  amplifier enable; high = amplifier on.
REQ-010 one_done  out  1  single-cycle registered pulse requesting the next sample (advances the controller's address).
REQ-011 busy_o  out  1  high while the state is PRIME or RUN.

Function
REQ-012 FSM SHALL have states IDLE, PRIME, RUN.
REQ-013 IDLE -> PRIME SHALL occur on the first clock with S_enable=1; PRIME SHALL last exactly 2 clocks to cover memory read latency.
REQ-014 On the last PRIME clock, duty SHALL load sample_i[SAMPLE_W-1 -: PWM_W] and the state SHALL go to RUN with pwm_cnt=0 and rep_cnt=0.
REQ-015 In RUN, pwm_cnt SHALL increment every clock and wrap from 2^PWM_W-1 to 0; rep_cnt SHALL increment on each wrap and wrap from REPEAT-1 to 0.
REQ-016 In RUN, pwm_o SHALL be registered (pwm_cnt < duty); duty=0 gives a constant low, duty=2^PWM_W-1 gives high for 2^PWM_W-1 of every 2^PWM_W clocks.
REQ-017 On the clock where pwm_cnt=2^PWM_W-1 and rep_cnt=REPEAT-1, duty SHALL reload from sample_i.
REQ-018 one_done SHALL be 1 for exactly one clock, on the clock after each duty load (including the PRIME load); one load SHALL produce exactly one pulse.
REQ-019 Sample period SHALL be exactly REPEAT*2^PWM_W clocks between consecutive one_done rising edges.
REQ-020 sample_i SHALL be sampled only at duty loads; changes at other times SHALL NOT affect pwm_o.
REQ-021 S_enable=0 in any state SHALL force IDLE on the next clock: pwm_o=0, audio_sd_o=0, busy_o=0, counters=0, and no one_done pulse.
REQ-022 S_enable re-asserted after a drop SHALL restart from PRIME.
REQ-023 audio_sd_o SHALL equal 1 in PRIME and RUN and 0 in IDLE.
REQ-024 one_done SHALL be glitch-free (direct flop output), because it is used as a clock edge downstream.

Reset
REQ-025 Reset=1 SHALL immediately force state=IDLE, pwm_o=0, audio_sd_o=0, one_done=0, busy_o=0, pwm_cnt=0, rep_cnt=0, duty=0, regardless of the clock.
REQ-026 Reset asserted mid-RUN SHALL abort the sample with no one_done pulse; after release with S_enable=1, operation SHALL resume via PRIME.

Verification (PWM_W=8, REPEAT=4, SAMPLE_W=16)
REQ-027 S_enable 0->1, sample_i=16'h8000 -> 2 clocks in PRIME, one_done pulse 1 clock later, then pwm_o high 128 of every 256 clocks.
REQ-028 Continuous RUN -> one_done pulses spaced exactly 1024 clocks apart, each 1 clock wide.
REQ-029 sample_i=16'h0000, then 16'hFF00 -> pwm_o constant 0 in the first sample period, high 255 of 256 clocks in the second.
REQ-030 sample_i toggled mid-period -> pwm_o duty unchanged until the next load.
REQ-031 S_enable dropped at rep_cnt=3, pwm_cnt=250 -> IDLE next clock, pwm_o=0, audio_sd_o=0, no one_done.
REQ-032 Reset pulsed asynchronously mid-RUN -> all outputs 0 without waiting for a clock edge; after release, PRIME->RUN resumes and one_done occurs 3 clocks after the first enabled edge.
